// File: rtl/mesa_pkg.sv
// mesa_pkg: shared constants and parser state encoding for the Mesa nibble decoder
package mesa_pkg;
    localparam logic [7:0] MESA_PREAMBLE = 8'hF0;
    localparam logic [3:0] MESA_CMD_WR = 4'h0;
    localparam logic [3:0] MESA_CMD_RD = 4'h1;
    typedef enum logic [2:0] {HUNT, SLOT, CMD, LEN, ADDR, DATA, SKIP} mesa_state_t;
endpackage

// File: rtl/mesa_nib2byte.sv
// mesa_nib2byte: preamble hunt and high/low nibble pairing into byte strobes
module mesa_nib2byte
    import mesa_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] nib_d,
    input  logic       nib_rdy,
    input  logic       realign,
    output logic       pre,
    output logic       byte_vld,
    output logic [7:0] byte_d
);
    logic       aligned_q, aligned_d, phase_q, phase_d;
    logic [3:0] prev_q, prev_d, hi_q, hi_d;
    always_comb begin
        pre = nib_rdy && !aligned_q && prev_q == MESA_PREAMBLE[7:4] && nib_d == MESA_PREAMBLE[3:0];
        byte_vld = nib_rdy && aligned_q && phase_q;
        byte_d = {hi_q, nib_d};
        aligned_d = realign ? 1'b0 : aligned_q || pre;
        phase_d = (realign || !aligned_q) ? 1'b0 : nib_rdy ? !phase_q : phase_q;
        prev_d = realign ? 4'h0 : (nib_rdy && !aligned_q) ? nib_d : prev_q;
        hi_d = (nib_rdy && aligned_q && !phase_q) ? nib_d : hi_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            aligned_q <= 1'b0;
            phase_q <= 1'b0;
            prev_q <= 4'h0;
            hi_q <= 4'h0;
        end else begin
            aligned_q <= aligned_d;
            phase_q <= phase_d;
            prev_q <= prev_d;
            hi_q <= hi_d;
        end
    end
endmodule

// File: rtl/mesa_nib_decode.sv
// mesa_nib_decode: Mesa packet parser turning packets for this slot into local-bus strobes
module mesa_nib_decode
    import mesa_pkg::*;
#(
    parameter logic [7:0]  MY_SLOT    = 8'h00,
    parameter logic [3:0]  MY_SUBSLOT = 4'h0,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  nib_d,
    input  logic        nib_rdy,
    output logic        lb_wr,
    output logic        lb_rd,
    output logic [31:0] lb_addr,
    output logic [31:0] lb_wr_d,
    output logic        busy
);
    mesa_state_t state_q, state_d;
    logic        match_q, match_d, wr_q, wr_d, rd_q, rd_d, realign, pre, byte_vld;
    logic [3:0]  cmd_q, cmd_d;
    logic [7:0]  cnt_q, cnt_d, byte_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] idle_q, idle_d;
    logic [23:0] wd_q, wd_d;
    logic [31:0] addr_q, addr_d, oaddr_q, oaddr_d, odata_q, odata_d;

    mesa_nib2byte u_nib2byte (
        .clk(clk), .reset(reset), .nib_d(nib_d), .nib_rdy(nib_rdy), .realign(realign),
        .pre(pre), .byte_vld(byte_vld), .byte_d(byte_d)
    );

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        cmd_d = cmd_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        addr_d = addr_q;
        wd_d = wd_q;
        wr_d = 1'b0;
        rd_d = 1'b0;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        idle_d = (nib_rdy || state_q == HUNT) ? 16'd0 : idle_q + 16'd1;
        if (state_q == HUNT) begin
            if (pre) state_d = SLOT;
        end else if (byte_vld) begin
            case (state_q)
                SLOT: begin
                    match_d = byte_d == MY_SLOT;
                    state_d = CMD;
                end
                CMD: begin
                    match_d = match_q && byte_d[7:4] == MY_SUBSLOT;
                    cmd_d = byte_d[3:0];
                    state_d = LEN;
                end
                LEN: begin
                    cnt_d = byte_d;
                    idx_d = 2'd0;
                    state_d = byte_d == 8'd0 ? HUNT :
                              (match_q && (cmd_q == MESA_CMD_WR || cmd_q == MESA_CMD_RD)) ? ADDR : SKIP;
                end
                ADDR: begin
                    addr_d = {addr_q[23:0], byte_d};
                    rd_d = idx_q == 2'd3 && cmd_q == MESA_CMD_RD;
                    oaddr_d = rd_d ? addr_d : oaddr_q;
                    state_d = idx_q != 2'd3 ? ADDR : rd_d ? SKIP : DATA;
                end
                DATA: begin
                    wd_d = {wd_q[15:0], byte_d};
                    wr_d = idx_q == 2'd3;
                    oaddr_d = wr_d ? addr_q : oaddr_q;
                    odata_d = wr_d ? {wd_q, byte_d} : odata_q;
                    addr_d = wr_d ? addr_q + 32'd4 : addr_q;
                end
                default: ;
            endcase
            // every payload byte counts down; the last one ends the packet
            if (state_q == ADDR || state_q == DATA || state_q == SKIP) begin
                cnt_d = cnt_q - 8'd1;
                idx_d = idx_q + 2'd1;
                if (cnt_q == 8'd1) state_d = HUNT;
            end
        end else if (!nib_rdy && idle_q >= TIMEOUT - 16'd1) begin
            state_d = HUNT;
        end
        realign = state_q != HUNT && state_d == HUNT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HUNT;
            match_q <= 1'b0;
            cmd_q <= 4'h0;
            cnt_q <= 8'd0;
            idx_q <= 2'd0;
            idle_q <= 16'd0;
            addr_q <= 32'd0;
            wd_q <= 24'd0;
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            oaddr_q <= 32'd0;
            odata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            cmd_q <= cmd_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            idle_q <= idle_d;
            addr_q <= addr_d;
            wd_q <= wd_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
        end
    end

    assign lb_wr = wr_q;
    assign lb_rd = rd_q;
    assign lb_addr = oaddr_q;
    assign lb_wr_d = odata_q;
    assign busy = state_q != HUNT;
endmodule

// File: tb/tb_mesa_nib_decode.sv
// tb_mesa_nib_decode: table-driven packet bench with a strobe scoreboard
module tb_mesa_nib_decode;
    localparam logic [15:0] TO = 16'd100;
    typedef struct {
        logic [7:0]  slot, cmd, len;
        logic [31:0] a, d0, d1;
        logic        rd;
        int          n;
        logic [31:0] ea0, ed0, ea1, ed1;
    } vec_t;
    typedef struct {
        logic        rd;
        logic [31:0] a, d;
        int          due;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, nib_rdy = 1'b0;
    logic [3:0]  nib_d = 4'h0;
    logic        lb_wr, lb_rd, busy;
    logic [31:0] lb_addr, lb_wr_d;
    int          total = 0, bad = 0, cyc = 0, t0, dt;
    exp_t        sb[$];
    exp_t        ez, me;
    vec_t        tv[12];

    mesa_nib_decode #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .nib_d(nib_d), .nib_rdy(nib_rdy),
        .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (lb_wr || lb_rd) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {30'd0, lb_wr, lb_rd}, 32'd0);
            end else begin
                me = sb.pop_front();
                chk("strobe_rd", {31'd0, lb_rd}, {31'd0, me.rd});
                chk("strobe_wr", {31'd0, lb_wr}, {31'd0, !me.rd});
                chk("strobe_addr", lb_addr, me.a);
                if (!me.rd) chk("strobe_data", lb_wr_d, me.d);
                chk("strobe_cycle", cyc, me.due);
            end
        end
    end

    task automatic nib(input logic [3:0] v, input bit push, input exp_t e);
        exp_t x;
        @(negedge clk);
        if (push) begin
            x = e;
            x.due = cyc + 1;
            sb.push_back(x);
        end
        nib_d = v;
        nib_rdy = 1'b1;
        @(negedge clk);
        nib_rdy = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push, input exp_t e);
        nib(b[7:4], 1'b0, ez);
        nib(b[3:0], push, e);
    endtask

    task automatic send_hdr(input logic [7:0] s, input logic [7:0] c, input logic [7:0] l);
        nib(4'hF, 1'b0, ez);
        nib(4'hF, 1'b0, ez);
        nib(4'hF, 1'b0, ez);
        nib(4'h0, 1'b0, ez);
        chk("busy_rise", {31'd0, busy}, 32'd1);
        send_byte(s, 1'b0, ez);
        send_byte(c, 1'b0, ez);
        send_byte(l, 1'b0, ez);
    endtask

    task automatic send_pkt(input vec_t v);
        int          w;
        exp_t        e;
        logic [31:0] wd;
        logic [7:0]  b;
        bit          hit;
        w = 0;
        send_hdr(v.slot, v.cmd, v.len);
        for (int p = 0; p < int'(v.len); p++) begin
            wd = p < 4 ? v.a : p < 8 ? v.d0 : p < 12 ? v.d1 : 32'hF0F0F0F0;
            b = wd[31 - 8 * (p % 4) -: 8];
            hit = w < v.n && (v.rd ? p == 3 : p == 7 + 4 * w);
            e = '{v.rd, w == 0 ? v.ea0 : v.ea1, w == 0 ? v.ed0 : v.ed1, 0};
            send_byte(b, hit, e);
            if (hit) w++;
        end
        @(negedge clk);
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("pending", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ez = '{1'b0, 32'd0, 32'd0, 0};
        tv[0]  = '{8'h00, 8'h00, 8'h08, 32'h12340000, 32'hDEADBEEF, 32'h0, 1'b0, 1, 32'h12340000, 32'hDEADBEEF, 32'h0, 32'h0};
        tv[1]  = '{8'h00, 8'h00, 8'h0C, 32'hFFFFFFFC, 32'h11111111, 32'h22222222, 1'b0, 2, 32'hFFFFFFFC, 32'h11111111, 32'h00000000, 32'h22222222};
        tv[2]  = '{8'h00, 8'h01, 8'h04, 32'h00000010, 32'h0, 32'h0, 1'b1, 1, 32'h00000010, 32'h0, 32'h0, 32'h0};
        tv[3]  = '{8'h05, 8'h00, 8'h08, 32'hF0F0F0F0, 32'h0FF0F00F, 32'h0, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        tv[4]  = '{8'h00, 8'h00, 8'h08, 32'h00000020, 32'hA5A55A5A, 32'h0, 1'b0, 1, 32'h00000020, 32'hA5A55A5A, 32'h0, 32'h0};
        tv[5]  = '{8'h00, 8'h00, 8'h07, 32'h00000100, 32'hAABBCCDD, 32'h0, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        tv[6]  = '{8'h00, 8'h10, 8'h08, 32'h00000200, 32'h11223344, 32'h0, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        tv[7]  = '{8'h00, 8'h02, 8'h08, 32'h00000300, 32'h55667788, 32'h0, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        tv[8]  = '{8'h00, 8'h00, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        tv[9]  = '{8'h00, 8'h01, 8'h02, 32'h00000400, 32'h0, 32'h0, 1'b1, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        tv[10] = '{8'h00, 8'h01, 8'h08, 32'hABCD0000, 32'hF0F0F0F0, 32'h0, 1'b1, 1, 32'hABCD0000, 32'h0, 32'h0, 32'h0};
        tv[11] = '{8'h00, 8'h00, 8'h0A, 32'h00000040, 32'hCAFEF00D, 32'hF0F00000, 1'b0, 1, 32'h00000040, 32'hCAFEF00D, 32'h0, 32'h0};

        repeat (3) @(negedge clk);
        chk("rst_wr", {31'd0, lb_wr}, 32'd0);
        chk("rst_rd", {31'd0, lb_rd}, 32'd0);
        chk("rst_addr", lb_addr, 32'd0);
        chk("rst_wdata", lb_wr_d, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) send_pkt(tv[i]);

        // stalled packet with a half byte pending must time out
        send_hdr(8'h00, 8'h00, 8'h08);
        for (int i = 1; i <= 5; i++) nib(4'(i), 1'b0, ez);
        t0 = cyc;
        chk("stall_busy", {31'd0, busy}, 32'd1);
        dt = -1;
        for (int k = 0; k < 3 * int'(TO) && dt < 0; k++) begin
            @(negedge clk);
            if (!busy) dt = cyc - t0;
        end
        chk("timeout_cycles", dt, {16'd0, TO});
        send_pkt(tv[4]);

        // reset in the middle of the data word
        send_hdr(8'h00, 8'h00, 8'h08);
        send_byte(8'h00, 1'b0, ez);
        send_byte(8'h00, 1'b0, ez);
        send_byte(8'h00, 1'b0, ez);
        send_byte(8'h50, 1'b0, ez);
        for (int i = 0; i < 6; i++) nib(4'h9, 1'b0, ez);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_addr", lb_addr, 32'd0);
        chk("mid_rst_wdata", lb_wr_d, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_wr", {31'd0, lb_wr}, 32'd0);

        // reset coinciding with the word-completing nibble
        send_hdr(8'h00, 8'h00, 8'h08);
        for (int i = 0; i < 4; i++) send_byte(8'h60, 1'b0, ez);
        for (int i = 0; i < 7; i++) nib(4'h3, 1'b0, ez);
        @(negedge clk);
        nib_d = 4'h3;
        nib_rdy = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        nib_rdy = 1'b0;
        reset = 1'b0;
        chk("rst_nib_wr", {31'd0, lb_wr}, 32'd0);
        chk("rst_nib_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst_nib_wr_late", {31'd0, lb_wr}, 32'd0);
        send_pkt(tv[11]);

        repeat (4) @(negedge clk);
        chk("final_pending", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
